// File: rtl/regfile_gp_pkg.sv
// rtl/regfile_gp_pkg.sv - shared sizes, types and helpers for the GP register file
//
// Purpose: width constants for GP data, GP target addresses and scoreboard
// counters, plus the matching typedefs used by regfile_gp and regfile_gp_sb.
// Ports: none (package).
package regfile_gp_pkg;

  localparam int SIZE_DATA   = 24;
  localparam int HBIT_DATA   = SIZE_DATA - 1;
  localparam int SIZE_TGT_GP = 4;
  localparam int HBIT_TGT_GP = SIZE_TGT_GP - 1;
  localparam int NUM_GP      = 1 << SIZE_TGT_GP;
  localparam int SIZE_SB_CNT = 3;
  localparam int HBIT_SB_CNT = SIZE_SB_CNT - 1;

  typedef logic [HBIT_DATA:0]   data_t;
  typedef logic [HBIT_TGT_GP:0] gp_addr_t;
  typedef logic [HBIT_SB_CNT:0] sb_cnt_t;
  typedef logic [NUM_GP-1:0]    gp_vec_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;
  localparam sb_cnt_t SB_CNT_ONE = sb_cnt_t'(1);

  // One-hot register select, all-zero when the strobe is low.
  function automatic gp_vec_t gp_onehot(input gp_addr_t addr, input logic en);
    gp_vec_t v;
    v = '0;
    if (en) v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_gp_sb.sv
// rtl/regfile_gp_sb.sv - per-register pending-write scoreboard
//
// Purpose: one saturating counter per GP register, counting writes issued but
// not yet retired by writeback; sticky over/underflow flag; pending vector.
// Optional feature macro: REGFILE_GP_BYPASS_EN (a register whose last pending
// write retires this cycle is not reported pending, unless re-issued).
// Ports:
//   iw_clk, iw_rst_n            clock, asynchronous active-low reset
//   iw_issue_we, iw_issue_addr  issue of a GP write (count up)
//   iw_retire_en, iw_retire_addr writeback retire (count down)
//   ow_pend                     per-register pending flags
//   ow_sb_err                   sticky overflow/underflow flag
module regfile_gp_sb
  import regfile_gp_pkg::*;
(
  input  logic     iw_clk,
  input  logic     iw_rst_n,
  input  logic     iw_issue_we,
  input  gp_addr_t iw_issue_addr,
  input  logic     iw_retire_en,
  input  gp_addr_t iw_retire_addr,
  output gp_vec_t  ow_pend,
  output logic     ow_sb_err
);

  sb_cnt_t cnt     [NUM_GP];
  sb_cnt_t cnt_nxt [NUM_GP];
  gp_vec_t inc_vec;
  gp_vec_t dec_vec;
  logic    err_set;

  always_comb begin
    inc_vec = gp_onehot(iw_issue_addr, iw_issue_we);
    dec_vec = gp_onehot(iw_retire_addr, iw_retire_en);
    err_set = 1'b0;
    for (int r = 0; r < NUM_GP; r++) begin
      cnt_nxt[r] = cnt[r];
      // Issue and retire on the same register cancel out, so no error either.
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt[r] == SB_CNT_MAX) err_set = 1'b1;
        else                      cnt_nxt[r] = cnt[r] + SB_CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt[r] == '0) err_set = 1'b1;
        else              cnt_nxt[r] = cnt[r] - SB_CNT_ONE;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_GP; r++) begin
      ow_pend[r] = (cnt[r] != '0);
`ifdef REGFILE_GP_BYPASS_EN
      // The retiring write is forwarded to the read port this cycle.
      if (cnt[r] == SB_CNT_ONE && dec_vec[r] && !inc_vec[r]) ow_pend[r] = 1'b0;
`endif
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int r = 0; r < NUM_GP; r++) cnt[r] <= '0;
      ow_sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_GP; r++) cnt[r] <= cnt_nxt[r];
      if (err_set) ow_sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_gp.sv
// rtl/regfile_gp.sv - 16 x 24-bit GP register file with write scoreboard
//
// Purpose: GP storage written by writeback, two combinational read ports and a
// hazard output from the pending-write scoreboard (regfile_gp_sb).
// Optional feature macro: REGFILE_GP_BYPASS_EN (write-to-read forwarding).
// Ports:
//   iw_clk, iw_rst_n                          clock, asynchronous active-low reset
//   iw_gp_write_addr/_data/_enable            writeback write port, retires a write
//   iw_issue_we, iw_issue_addr                issuing instruction's GP target
//   iw_src_a_addr/_valid, iw_src_b_addr/_valid read addresses and use qualifiers
//   ow_src_a_data, ow_src_b_data              read data
//   ow_hazard                                 a valid source has a write in flight
//   ow_sb_err                                 sticky scoreboard over/underflow
module regfile_gp
  import regfile_gp_pkg::*;
(
  input  logic                   iw_clk,
  input  logic                   iw_rst_n,
  input  logic [HBIT_TGT_GP:0]   iw_gp_write_addr,
  input  logic [HBIT_DATA:0]     iw_gp_write_data,
  input  logic                   iw_gp_write_enable,
  input  logic                   iw_issue_we,
  input  logic [HBIT_TGT_GP:0]   iw_issue_addr,
  input  logic [HBIT_TGT_GP:0]   iw_src_a_addr,
  input  logic                   iw_src_a_valid,
  input  logic [HBIT_TGT_GP:0]   iw_src_b_addr,
  input  logic                   iw_src_b_valid,
  output logic [HBIT_DATA:0]     ow_src_a_data,
  output logic [HBIT_DATA:0]     ow_src_b_data,
  output logic                   ow_hazard,
  output logic                   ow_sb_err
);

  data_t   regs [NUM_GP];
  gp_vec_t pend;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int r = 0; r < NUM_GP; r++) regs[r] <= '0;
    end else if (iw_gp_write_enable) begin
      regs[iw_gp_write_addr] <= iw_gp_write_data;
    end
  end

  always_comb begin
    ow_src_a_data = regs[iw_src_a_addr];
    ow_src_b_data = regs[iw_src_b_addr];
`ifdef REGFILE_GP_BYPASS_EN
    // Forwarding is held off during reset so the read ports read as zero.
    if (iw_rst_n && iw_gp_write_enable && iw_gp_write_addr == iw_src_a_addr)
      ow_src_a_data = iw_gp_write_data;
    if (iw_rst_n && iw_gp_write_enable && iw_gp_write_addr == iw_src_b_addr)
      ow_src_b_data = iw_gp_write_data;
`endif
  end

  assign ow_hazard = (iw_src_a_valid && pend[iw_src_a_addr]) ||
                     (iw_src_b_valid && pend[iw_src_b_addr]);

  regfile_gp_sb u_sb (
    .iw_clk         (iw_clk),
    .iw_rst_n       (iw_rst_n),
    .iw_issue_we    (iw_issue_we),
    .iw_issue_addr  (iw_issue_addr),
    .iw_retire_en   (iw_gp_write_enable),
    .iw_retire_addr (iw_gp_write_addr),
    .ow_pend        (pend),
    .ow_sb_err      (ow_sb_err)
  );

endmodule

// File: tb/tb_regfile_gp.sv
// tb/tb_regfile_gp.sv - directed scoreboard bench for regfile_gp
module tb_regfile_gp;
  import regfile_gp_pkg::*;

`ifdef REGFILE_GP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        iw_clk = 1'b0;
  logic        iw_rst_n;
  logic [3:0]  iw_gp_write_addr;
  logic [23:0] iw_gp_write_data;
  logic        iw_gp_write_enable;
  logic        iw_issue_we;
  logic [3:0]  iw_issue_addr;
  logic [3:0]  iw_src_a_addr;
  logic        iw_src_a_valid;
  logic [3:0]  iw_src_b_addr;
  logic        iw_src_b_valid;
  logic [23:0] ow_src_a_data;
  logic [23:0] ow_src_b_data;
  logic        ow_hazard;
  logic        ow_sb_err;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  string       tag_q[$];

  always #5 iw_clk = ~iw_clk;

  regfile_gp dut (
    .iw_clk             (iw_clk),
    .iw_rst_n           (iw_rst_n),
    .iw_gp_write_addr   (iw_gp_write_addr),
    .iw_gp_write_data   (iw_gp_write_data),
    .iw_gp_write_enable (iw_gp_write_enable),
    .iw_issue_we        (iw_issue_we),
    .iw_issue_addr      (iw_issue_addr),
    .iw_src_a_addr      (iw_src_a_addr),
    .iw_src_a_valid     (iw_src_a_valid),
    .iw_src_b_addr      (iw_src_b_addr),
    .iw_src_b_valid     (iw_src_b_valid),
    .ow_src_a_data      (ow_src_a_data),
    .ow_src_b_data      (ow_src_b_data),
    .ow_hazard          (ow_hazard),
    .ow_sb_err          (ow_sb_err)
  );

  task automatic push(input string tag, input logic [23:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input logic [23:0] obs);
    logic [23:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic cyc();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic samp();
    @(negedge iw_clk);
  endtask

  initial begin
    iw_rst_n = 1'b0;
    iw_gp_write_addr = '0; iw_gp_write_data = '0; iw_gp_write_enable = 1'b0;
    iw_issue_we = 1'b0; iw_issue_addr = '0;
    iw_src_a_addr = '0; iw_src_a_valid = 1'b0;
    iw_src_b_addr = '0; iw_src_b_valid = 1'b0;
    cyc(); cyc();
    iw_rst_n = 1'b1;

    // Reset state
    samp();
    push("rst_data_a", 24'h0);   chk(ow_src_a_data);
    push("rst_err", 24'h0);      chk({23'b0, ow_sb_err});

    // Traffic, then asynchronous reset in mid-cycle
    cyc();
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd1; iw_gp_write_data = 24'h111111;
    iw_issue_we = 1'b1; iw_issue_addr = 4'd9;
    cyc();
    iw_gp_write_enable = 1'b0; iw_issue_we = 1'b0;
    iw_src_a_addr = 4'd1; iw_src_b_addr = 4'd9; iw_src_b_valid = 1'b1;
    samp();
    push("pre_rst_data", 24'h111111); chk(ow_src_a_data);
    push("pre_rst_haz", 24'h1);       chk({23'b0, ow_hazard});
    push("pre_rst_err", 24'h1);       chk({23'b0, ow_sb_err});
    #2 iw_rst_n = 1'b0;
    #1;
    push("mid_rst_data", 24'h0); chk(ow_src_a_data);
    push("mid_rst_haz", 24'h0);  chk({23'b0, ow_hazard});
    push("mid_rst_err", 24'h0);  chk({23'b0, ow_sb_err});
    cyc();
    iw_rst_n = 1'b1; iw_src_b_valid = 1'b0;

    // Write r3 then read it the next cycle
    iw_issue_we = 1'b1; iw_issue_addr = 4'd3;
    cyc();
    iw_issue_we = 1'b0;
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd3; iw_gp_write_data = 24'hABCDEF;
    cyc();
    iw_gp_write_enable = 1'b0; iw_src_a_addr = 4'd3;
    samp();
    push("r3_read", 24'hABCDEF); chk(ow_src_a_data);
    push("r3_err", 24'h0);       chk({23'b0, ow_sb_err});

    // Same-cycle read of r5 while it is written
    cyc();
    iw_issue_we = 1'b1; iw_issue_addr = 4'd5;
    cyc();
    iw_issue_we = 1'b0;
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd5; iw_gp_write_data = 24'h123456;
    iw_src_a_addr = 4'd5; iw_src_a_valid = 1'b1;
    samp();
    push("r5_same_cycle", BYP ? 24'h123456 : 24'h0); chk(ow_src_a_data);
    push("r5_retire_haz", BYP ? 24'h0 : 24'h1);      chk({23'b0, ow_hazard});
    cyc();
    iw_gp_write_enable = 1'b0;
    samp();
    push("r5_next", 24'h123456); chk(ow_src_a_data);
    push("r5_haz_clr", 24'h0);   chk({23'b0, ow_hazard});

    // Issue r7: hazard from next cycle, qualifier gating, retire timing
    cyc();
    iw_issue_we = 1'b1; iw_issue_addr = 4'd7; iw_src_a_addr = 4'd7;
    samp();
    push("r7_issue_cycle", 24'h0); chk({23'b0, ow_hazard});
    cyc();
    iw_issue_we = 1'b0;
    samp();
    push("r7_pending", 24'h1); chk({23'b0, ow_hazard});
    #1 iw_src_a_valid = 1'b0;
    #1;
    push("r7_invalid_a", 24'h0); chk({23'b0, ow_hazard});
    iw_src_b_addr = 4'd7; iw_src_b_valid = 1'b1;
    #1;
    push("r7_port_b", 24'h1); chk({23'b0, ow_hazard});
    iw_src_b_valid = 1'b0; iw_src_a_valid = 1'b1;
    cyc();
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd7; iw_gp_write_data = 24'h000777;
    samp();
    push("r7_retire_cycle", BYP ? 24'h0 : 24'h1); chk({23'b0, ow_hazard});
    cyc();
    iw_gp_write_enable = 1'b0;
    samp();
    push("r7_after_retire", 24'h0); chk({23'b0, ow_hazard});

    // r2: three issues, retire+issue same cycle, three retires
    cyc();
    iw_issue_we = 1'b1; iw_issue_addr = 4'd2; iw_src_a_addr = 4'd2;
    cyc(); cyc(); cyc();
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd2; iw_gp_write_data = 24'h000222;
    samp();
    push("r2_issue_retire", 24'h1); chk({23'b0, ow_hazard});
    cyc();
    iw_issue_we = 1'b0;
    samp();
    push("r2_ret1", 24'h1); chk({23'b0, ow_hazard});
    cyc();
    samp();
    push("r2_ret2", 24'h1); chk({23'b0, ow_hazard});
    cyc();
    samp();
    push("r2_ret3", BYP ? 24'h0 : 24'h1); chk({23'b0, ow_hazard});
    cyc();
    iw_gp_write_enable = 1'b0;
    samp();
    push("r2_clear", 24'h0); chk({23'b0, ow_hazard});
    push("r2_err", 24'h0);   chk({23'b0, ow_sb_err});

    // r9: eight issues saturate at 7 and set the sticky error
    cyc();
    iw_issue_we = 1'b1; iw_issue_addr = 4'd9; iw_src_a_addr = 4'd9;
    repeat (7) cyc();
    samp();
    push("r9_at_max_err", 24'h0); chk({23'b0, ow_sb_err});
    push("r9_at_max_haz", 24'h1); chk({23'b0, ow_hazard});
    cyc();
    iw_issue_we = 1'b0;
    samp();
    push("r9_overflow_err", 24'h1); chk({23'b0, ow_sb_err});
    push("r9_sat_haz", 24'h1);      chk({23'b0, ow_hazard});
    cyc();
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd9; iw_gp_write_data = 24'h000999;
    repeat (5) cyc();
    samp();
    push("r9_ret6", 24'h1); chk({23'b0, ow_hazard});
    cyc();
    samp();
    push("r9_ret7", BYP ? 24'h0 : 24'h1); chk({23'b0, ow_hazard});
    cyc();
    iw_gp_write_enable = 1'b0;
    samp();
    push("r9_clear", 24'h0);     chk({23'b0, ow_hazard});
    push("r9_err_sticky", 24'h1); chk({23'b0, ow_sb_err});

    // Underflow on r4 after a fresh reset
    cyc();
    iw_rst_n = 1'b0;
    cyc();
    iw_rst_n = 1'b1;
    samp();
    push("rst2_err", 24'h0); chk({23'b0, ow_sb_err});
    cyc();
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd4; iw_gp_write_data = 24'h444444;
    cyc();
    iw_gp_write_enable = 1'b0; iw_src_a_addr = 4'd4; iw_src_a_valid = 1'b1;
    samp();
    push("r4_data", 24'h444444); chk(ow_src_a_data);
    push("r4_haz", 24'h0);       chk({23'b0, ow_hazard});
    push("r4_underflow", 24'h1); chk({23'b0, ow_sb_err});
    cyc();
    iw_issue_we = 1'b1; iw_issue_addr = 4'd4;
    cyc();
    // Retire r4 while issuing r6: independent updates
    iw_issue_addr = 4'd6;
    iw_gp_write_enable = 1'b1; iw_gp_write_addr = 4'd4; iw_gp_write_data = 24'h004444;
    samp();
    push("r4_pending", BYP ? 24'h0 : 24'h1); chk({23'b0, ow_hazard});
    cyc();
    iw_issue_we = 1'b0; iw_gp_write_enable = 1'b0;
    iw_src_b_addr = 4'd6; iw_src_b_valid = 1'b1; iw_src_a_valid = 1'b0;
    samp();
    push("r6_pending", 24'h1); chk({23'b0, ow_hazard});
    #1 iw_src_b_valid = 1'b0; iw_src_a_valid = 1'b1;
    #1;
    push("r4_cnt_zero", 24'h0); chk({23'b0, ow_hazard});

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
